// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first add/subtract with valid/ready on both sides.
// Define SERIAL_ADDSUB_FLAGS_EN to compute the ovf and zero flags.
module serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res;

  fa_cell u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_res    = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Subtraction is A + ~B + 1: invert B on load and seed the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res;
      r_carry <= w_co;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_res;
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic r_cmsb;
  logic r_ovf;
  logic r_zero;

  // Carry into the MSB cell is captured one edge before the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmsb <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == SHIFT) begin
      if (r_cnt == LAST - 1'b1) r_cmsb <= w_co;
      if (w_last) begin
        r_ovf  <= r_cmsb ^ w_co;
        r_zero <= (w_res == '0);
      end
    end
  end

  assign ovf  = r_ovf;
  assign zero = r_zero;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
